// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and widths for the ARM-subset core memory path
package arm_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int REG_ADDR_W  = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_LOW,
    MEM_HIGH,
    MEM_DONE
  } mem_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - two half-word SRAM access sequencer with pipeline freeze
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] SRAM_BASE   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   ready,
  output logic [31:0]            rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_we_n
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  mem_state_e                 state, state_nx;
  logic [2:0]                 cnt;
  logic [SRAM_ADDR_W-2:0]     widx_q;
  logic [SRAM_ADDR_W-2:0]     widx_d;
  logic [31:0]                wdata_q;
  logic                       is_store_q;
  logic [SRAM_DATA_W-1:0]     rd_lo, rd_hi;
  logic                       mem_req;
  logic                       last;

  assign mem_req = mem_r_en | mem_w_en;
  assign last    = (cnt == LAST_CNT);
  assign widx_d  = 17'((addr - SRAM_BASE) >> 2);
  assign rdata   = {rd_hi, rd_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MEM_IDLE;
      cnt        <= '0;
      widx_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      rd_lo      <= '0;
      rd_hi      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == state) ? cnt + 3'd1 : 3'd0;
      // A request with both enables set is handled as a store
      if (state == MEM_IDLE && mem_req) begin
        widx_q     <= widx_d;
        wdata_q    <= wdata;
        is_store_q <= mem_w_en;
      end
      if (state == MEM_LOW && last && !is_store_q) rd_lo <= sram_dq_i;
      if (state == MEM_HIGH && last && !is_store_q) rd_hi <= sram_dq_i;
    end
  end

  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    case (state)
      MEM_IDLE: begin
        ready = ~mem_req;
        if (mem_req) state_nx = MEM_LOW;
      end
      MEM_LOW: begin
        sram_addr = {widx_q, 1'b0};
        if (is_store_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
          sram_dq_o  = wdata_q[15:0];
        end
        if (last) state_nx = MEM_HIGH;
      end
      MEM_HIGH: begin
        sram_addr = {widx_q, 1'b1};
        if (is_store_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
          sram_dq_o  = wdata_q[31:16];
        end
        if (last) state_nx = MEM_DONE;
      end
      MEM_DONE: begin
        ready    = 1'b1;
        state_nx = MEM_IDLE;
      end
      default: state_nx = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_wb_sram_stage.sv
// rtl/mem_wb_sram_stage.sv - memory stage with SRAM access and MEM/WB pipeline register
module mem_wb_sram_stage
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] SRAM_BASE   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   MEM_R_en,
  input  logic                   MEM_W_en,
  input  logic                   WB_en_in,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_Rm,
  input  logic [REG_ADDR_W-1:0]  Dest,
  output logic                   ready,
  output logic                   WB_WB_en,
  output logic [REG_ADDR_W-1:0]  WB_Dest,
  output logic [31:0]            WB_Value,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] SRAM_DQ_o,
  output logic                   SRAM_DQ_oe,
  input  logic [SRAM_DATA_W-1:0] SRAM_DQ_i,
  output logic                   SRAM_WE_N
);

  logic [31:0] rdata;
  logic        is_load;
  logic [31:0] wb_value_d;

  sram_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .SRAM_BASE  (SRAM_BASE)
  ) u_sram_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_r_en  (MEM_R_en),
    .mem_w_en  (MEM_W_en),
    .addr      (ALU_Res),
    .wdata     (Val_Rm),
    .ready     (ready),
    .rdata     (rdata),
    .sram_addr (SRAM_ADDR),
    .sram_dq_o (SRAM_DQ_o),
    .sram_dq_oe(SRAM_DQ_oe),
    .sram_dq_i (SRAM_DQ_i),
    .sram_we_n (SRAM_WE_N)
  );

  // Inputs are frozen upstream while ready is low, so they still describe the op in DONE
  assign is_load    = MEM_R_en & ~MEM_W_en;
  assign wb_value_d = is_load ? rdata : ALU_Res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_WB_en <= 1'b0;
      WB_Dest  <= '0;
      WB_Value <= '0;
    end else if (ready) begin
      WB_WB_en <= WB_en_in;
      WB_Dest  <= Dest;
      WB_Value <= wb_value_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_sram_stage.sv
// tb/tb_mem_wb_sram_stage.sv - self-checking bench for mem_wb_sram_stage (WAIT_CYCLES 0 and 1)
module tb_mem_wb_sram_stage;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r[2], mem_w[2], wb_en_in[2];
  logic [31:0] alu[2], val[2];
  logic [3:0]  dest[2];
  logic        ready[2], wb_en_o[2];
  logic [3:0]  wb_dest[2];
  logic [31:0] wb_val[2];
  logic [17:0] s_addr[2];
  logic [15:0] s_dq_o[2], s_dq_i[2];
  logic        s_oe[2], s_we_n[2];
  logic [15:0] sram[2][64];

  int checks = 0;
  int errors = 0;
  logic [34:0] wlog[$];
  logic [17:0] alog[$];
  logic [34:0] exp_w[4];
  logic [17:0] exp_a[10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_wb_sram_stage #(.WAIT_CYCLES(g), .SRAM_BASE(BASE)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_R_en(mem_r[g]), .MEM_W_en(mem_w[g]), .WB_en_in(wb_en_in[g]),
      .ALU_Res(alu[g]), .Val_Rm(val[g]), .Dest(dest[g]),
      .ready(ready[g]), .WB_WB_en(wb_en_o[g]), .WB_Dest(wb_dest[g]), .WB_Value(wb_val[g]),
      .SRAM_ADDR(s_addr[g]), .SRAM_DQ_o(s_dq_o[g]), .SRAM_DQ_oe(s_oe[g]),
      .SRAM_DQ_i(s_dq_i[g]), .SRAM_WE_N(s_we_n[g])
    );
    assign s_dq_i[g] = sram[g][s_addr[g][5:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Asynchronous SRAM: write strobe sampled mid-cycle, reads are combinational
  initial begin : sram_model
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) sram[d][i] = 16'hA000 + 16'(d * 256 + i);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (s_we_n[d] === 1'b0) begin
          sram[d][s_addr[d][5:0]] = s_dq_o[d];
          wlog.push_back({1'(d), s_addr[d], s_dq_o[d]});
        end
    end
  end

  // Transaction model: k counts cycles since a memory op was first seen (-1 = none)
  initial begin : model
    int          k[2];
    bit          t_st[2];
    logic [16:0] t_widx[2];
    logic [31:0] t_data[2];
    logic        m_en[2];
    logic [3:0]  m_dest[2];
    logic [31:0] m_val[2];
    logic [15:0] ref_mem[2][64];
    bit          in_lo, in_hi, e_ready, e_drv;
    logic [17:0] e_addr;
    logic [5:0]  lo_i, hi_i;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) ref_mem[d][i] = 16'hA000 + 16'(d * 256 + i);
      k[d] = -1; m_en[d] = 1'b0; m_dest[d] = '0; m_val[d] = '0;
      t_st[d] = 1'b0; t_widx[d] = '0; t_data[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          k[d] = -1; m_en[d] = 1'b0; m_dest[d] = '0; m_val[d] = '0;
        end else begin
          chk($sformatf("wb_en[%0d]", d), 64'(wb_en_o[d]), 64'(m_en[d]));
          chk($sformatf("wb_dest[%0d]", d), 64'(wb_dest[d]), 64'(m_dest[d]));
          chk($sformatf("wb_value[%0d]", d), 64'(wb_val[d]), 64'(m_val[d]));
          if (k[d] < 0 && (mem_r[d] || mem_w[d])) begin
            k[d] = 0;
            t_st[d] = mem_w[d];
            t_widx[d] = 17'((alu[d] - BASE) >> 2);
            t_data[d] = val[d];
          end
          in_lo   = (k[d] >= 1) && (k[d] <= d + 1);
          in_hi   = (k[d] >= d + 2) && (k[d] <= 2 * d + 2);
          e_ready = (k[d] < 0) || (k[d] == 2 * d + 3);
          e_drv   = (in_lo || in_hi) && t_st[d];
          e_addr  = in_lo ? {t_widx[d], 1'b0} : (in_hi ? {t_widx[d], 1'b1} : 18'd0);
          chk($sformatf("ready[%0d]", d), 64'(ready[d]), 64'(e_ready));
          chk($sformatf("sram_addr[%0d]", d), 64'(s_addr[d]), 64'(e_addr));
          chk($sformatf("sram_we_n[%0d]", d), 64'(s_we_n[d]), 64'(!e_drv));
          chk($sformatf("sram_oe[%0d]", d), 64'(s_oe[d]), 64'(e_drv));
          if (e_drv)
            chk($sformatf("sram_dq_o[%0d]", d), 64'(s_dq_o[d]),
                64'(in_lo ? t_data[d][15:0] : t_data[d][31:16]));
          if (e_ready) begin
            lo_i = {t_widx[d][4:0], 1'b0};
            hi_i = {t_widx[d][4:0], 1'b1};
            if (k[d] >= 0 && !t_st[d]) m_val[d] = {ref_mem[d][hi_i], ref_mem[d][lo_i]};
            else m_val[d] = alu[d];
            if (k[d] >= 0 && t_st[d]) begin
              ref_mem[d][lo_i] = t_data[d][15:0];
              ref_mem[d][hi_i] = t_data[d][31:16];
            end
            m_en[d] = wb_en_in[d];
            m_dest[d] = dest[d];
            k[d] = -1;
          end else begin
            k[d]++;
          end
        end
      end
    end
  end

  task automatic idle(input int d);
    mem_r[d] = 1'b0; mem_w[d] = 1'b0; wb_en_in[d] = 1'b0;
    alu[d] = '0; val[d] = '0; dest[d] = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the op
  task automatic do_op(input int d, input logic r, input logic w, input logic we,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] ds,
                       output int stalls);
    mem_r[d] = r; mem_w[d] = w; wb_en_in[d] = we; alu[d] = a; val[d] = v; dest[d] = ds;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready[d]) break;
      stalls++;
      if (d == 1) alog.push_back(s_addr[d]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int st;
    rst_n = 1'b0;
    idle(0);
    idle(1);
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready[1]), 64'd1);
    chk("rst_we_n", 64'(s_we_n[1]), 64'd1);
    chk("rst_oe", 64'(s_oe[1]), 64'd0);
    chk("rst_addr", 64'(s_addr[1]), 64'd0);
    chk("rst_wb_value", 64'(wb_val[1]), 64'd0);
    chk("rst_wb_en", 64'(wb_en_o[1]), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    wlog.delete();
    do_op(1, 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0, st);
    chk("store_stall", 64'(st), 64'd5);
    chk("store_wlog_len", 64'(wlog.size()), 64'd4);
    exp_w[0] = {1'b1, 18'd2, 16'hBEEF};
    exp_w[1] = {1'b1, 18'd2, 16'hBEEF};
    exp_w[2] = {1'b1, 18'd3, 16'hDEAD};
    exp_w[3] = {1'b1, 18'd3, 16'hDEAD};
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("store_write%0d", i), 64'(wlog[i]), 64'(exp_w[i]));
    chk("store_wb_en", 64'(wb_en_o[1]), 64'd0);

    do_op(1, 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd5, st);
    chk("load_stall", 64'(st), 64'd5);
    chk("load_value", 64'(wb_val[1]), 64'hDEADBEEF);
    chk("load_dest", 64'(wb_dest[1]), 64'd5);
    chk("load_wb_en", 64'(wb_en_o[1]), 64'd1);

    do_op(1, 1'b0, 1'b0, 1'b1, 32'h12, 32'd0, 4'd3, st);
    chk("alu_stall", 64'(st), 64'd0);
    chk("alu_value", 64'(wb_val[1]), 64'h12);
    chk("alu_dest", 64'(wb_dest[1]), 64'd3);
    chk("alu_wb_en", 64'(wb_en_o[1]), 64'd1);

    alog.delete();
    do_op(1, 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd1, st);
    chk("b2b_stall0", 64'(st), 64'd5);
    chk("b2b_value0", 64'(wb_val[1]), 64'hA101A100);
    do_op(1, 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd2, st);
    chk("b2b_stall1", 64'(st), 64'd5);
    chk("b2b_value1", 64'(wb_val[1]), 64'hA105A104);
    exp_a = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd0, 18'd4, 18'd4, 18'd5, 18'd5};
    chk("b2b_alog_len", 64'(alog.size()), 64'd10);
    if (alog.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("b2b_addr%0d", i), 64'(alog[i]), 64'(exp_a[i]));

    mem_r[1] = 1'b0; mem_w[1] = 1'b1; wb_en_in[1] = 1'b0;
    alu[1] = 32'd1040; val[1] = 32'hCAFEF00D; dest[1] = 4'd0;
    repeat (4) @(negedge clk);
    chk("pre_rst_we_n", 64'(s_we_n[1]), 64'd0);
    chk("pre_rst_addr", 64'(s_addr[1]), 64'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", 64'(s_we_n[1]), 64'd1);
    chk("mid_rst_oe", 64'(s_oe[1]), 64'd0);
    chk("mid_rst_wb_en", 64'(wb_en_o[1]), 64'd0);
    chk("mid_rst_wb_dest", 64'(wb_dest[1]), 64'd0);
    chk("mid_rst_wb_value", 64'(wb_val[1]), 64'd0);
    idle(1);
    #1;
    chk("mid_rst_ready", 64'(ready[1]), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    wlog.delete();
    do_op(0, 1'b0, 1'b1, 1'b0, 32'd1024, 32'h13579BDF, 4'd0, st);
    chk("w0_store_stall", 64'(st), 64'd3);
    chk("w0_wlog_len", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("w0_write0", 64'(wlog[0]), 64'({1'b0, 18'd0, 16'h9BDF}));
      chk("w0_write1", 64'(wlog[1]), 64'({1'b0, 18'd1, 16'h1357}));
    end
    do_op(0, 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd7, st);
    chk("w0_load_stall", 64'(st), 64'd3);
    chk("w0_load_value", 64'(wb_val[0]), 64'h13579BDF);
    chk("w0_load_dest", 64'(wb_dest[0]), 64'd7);
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
